// File: rtl/fibo_seq_engine.sv
// Iterative two-seed additive recurrence engine (Fibonacci / Lucas / custom seeds).
// Computes term n with sticky per-term overflow saturation, abort and a done/hold handshake.
module fibo_seq_engine #(
  parameter int DATA_W = 16,
  parameter int IDX_W  = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [1:0]        mode,
  input  logic [IDX_W-1:0]  n_in,
  input  logic [DATA_W-1:0] seed0,
  input  logic [DATA_W-1:0] seed1,
  output logic [DATA_W-1:0] result,
  output logic              done,
  output logic              busy,
  output logic              overflow
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t            state;
  logic [DATA_W-1:0] a;
  logic [DATA_W-1:0] b;
  logic [IDX_W:0]    cnt;
  logic [IDX_W-1:0]  n;
  logic              a_ovf;
  logic              b_ovf;
  logic [DATA_W:0]   sum;
  logic [DATA_W-1:0] init_a;
  logic [DATA_W-1:0] init_b;

  function automatic logic [DATA_W-1:0] saturate(input logic [DATA_W-1:0] v,
                                                 input logic ovf);
    return ovf ? {DATA_W{1'b1}} : v;
  endfunction

  assign sum = {1'b0, a} + {1'b0, b};

  // Seed pair for T(0), T(1); mode 11 falls back to Fibonacci.
  always_comb begin
    init_a = '0;
    init_b = DATA_W'(1);
    case (mode)
      2'b01: begin
        init_a = DATA_W'(2);
        init_b = DATA_W'(1);
      end
      2'b10: begin
        init_a = seed0;
        init_b = seed1;
      end
      default: begin
        init_a = '0;
        init_b = DATA_W'(1);
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      result   <= '0;
      done     <= 1'b0;
      busy     <= 1'b0;
      overflow <= 1'b0;
      a        <= '0;
      b        <= '0;
      cnt      <= '0;
      n        <= '0;
      a_ovf    <= 1'b0;
      b_ovf    <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            n        <= n_in;
            a        <= init_a;
            b        <= init_b;
            cnt      <= '0;
            a_ovf    <= 1'b0;
            b_ovf    <= 1'b0;
            done     <= 1'b0;
            overflow <= 1'b0;
            busy     <= 1'b1;
            state    <= CALC;
          end
        end
        CALC: begin
          if (abort) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else if (cnt == {1'b0, n}) begin
            result   <= saturate(a, a_ovf);
            overflow <= a_ovf;
            done     <= 1'b1;
            busy     <= 1'b0;
            state    <= DONE;
          end else begin
            // a tracks T(cnt), b tracks T(cnt+1); overflow flags shift with their terms.
            a     <= b;
            b     <= sum[DATA_W-1:0];
            a_ovf <= b_ovf;
            b_ovf <= a_ovf | b_ovf | sum[DATA_W];
            cnt   <= cnt + 1'b1;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fibo_seq_engine.sv
// Directed bench for fibo_seq_engine: vector table of single calculations plus
// hand-written abort, restart, start-in-CALC and async-reset sequences.
module tb_fibo_seq_engine;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        abort;
  logic [1:0]  mode;
  logic [4:0]  n_in;
  logic [15:0] seed0;
  logic [15:0] seed1;
  logic [15:0] result;
  logic        done;
  logic        busy;
  logic        overflow;

  int n_cmp = 0;
  int n_err = 0;

  fibo_seq_engine #(.DATA_W(16), .IDX_W(5)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .mode(mode),
    .n_in(n_in), .seed0(seed0), .seed1(seed1), .result(result),
    .done(done), .busy(busy), .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  mode;
    int          n;
    logic [15:0] s0;
    logic [15:0] s1;
    logic [15:0] res;
    logic        ovf;
    int          lat;
  } vec_t;

  vec_t tbl[13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Issue a one-cycle start; returns 1 ns after the accepting edge E0.
  task automatic launch(input logic [1:0] m, input int n, input logic [15:0] s0,
                        input logic [15:0] s1);
    @(negedge clk);
    mode  = m;
    n_in  = 5'(n);
    seed0 = s0;
    seed1 = s1;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    mode  = 2'b01;
    n_in  = ~5'(n);
    seed0 = 16'hAAAA;
    seed1 = 16'h5555;
  endtask

  // Counts edges after E0 until done; bcnt counts samples with busy high before done.
  task automatic wait_done(input string name, output int lat, output int bcnt);
    lat  = 0;
    bcnt = busy ? 1 : 0;
    for (int k = 1; k <= 200; k++) begin
      @(posedge clk);
      #1;
      if (done) begin
        lat = k;
        break;
      end
      if (busy) bcnt++;
    end
    if (lat == 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s_timeout: done not seen, expected within 200 cycles", name);
    end
  endtask

  initial begin
    int lat;
    int bcnt;
    logic [15:0] last_res;

    tbl[0]  = '{2'b00,  5, 16'h0000, 16'h0000, 16'd5,     1'b0,  6};
    tbl[1]  = '{2'b00,  9, 16'h0000, 16'h0000, 16'd34,    1'b0, 10};
    tbl[2]  = '{2'b00, 12, 16'h0000, 16'h0000, 16'd144,   1'b0, 13};
    tbl[3]  = '{2'b01,  5, 16'h0000, 16'h0000, 16'd11,    1'b0,  6};
    tbl[4]  = '{2'b01,  0, 16'h0000, 16'h0000, 16'd2,     1'b0,  1};
    tbl[5]  = '{2'b10,  3, 16'd3,    16'd4,    16'd11,    1'b0,  4};
    tbl[6]  = '{2'b11,  7, 16'h0000, 16'h0000, 16'd13,    1'b0,  8};
    tbl[7]  = '{2'b00, 24, 16'h0000, 16'h0000, 16'd46368, 1'b0, 25};
    tbl[8]  = '{2'b00, 25, 16'h0000, 16'h0000, 16'hFFFF,  1'b1, 26};
    tbl[9]  = '{2'b00, 31, 16'h0000, 16'h0000, 16'hFFFF,  1'b1, 32};
    tbl[10] = '{2'b10,  1, 16'hFFFF, 16'hFFFF, 16'hFFFF,  1'b0,  2};
    tbl[11] = '{2'b10,  2, 16'hFFFF, 16'hFFFF, 16'hFFFF,  1'b1,  3};
    tbl[12] = '{2'b10,  0, 16'h1234, 16'h0007, 16'h1234,  1'b0,  1};

    reset = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    mode  = 2'b00;
    n_in  = '0;
    seed0 = '0;
    seed1 = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_result", 32'(result), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_ovf", 32'(overflow), 32'h0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 13; i++) begin
      launch(tbl[i].mode, tbl[i].n, tbl[i].s0, tbl[i].s1);
      wait_done($sformatf("v%0d", i), lat, bcnt);
      chk($sformatf("v%0d_lat", i), 32'(lat), 32'(tbl[i].lat));
      chk($sformatf("v%0d_res", i), 32'(result), 32'(tbl[i].res));
      chk($sformatf("v%0d_ovf", i), 32'(overflow), 32'(tbl[i].ovf));
      chk($sformatf("v%0d_busy", i), 32'(bcnt), 32'(tbl[i].n + 1));
    end
    last_res = tbl[12].res;

    // Abort at E0+4 with start also high: back to IDLE, result untouched.
    launch(2'b00, 12, 16'h0, 16'h0);
    repeat (3) @(posedge clk);
    #1;
    abort = 1'b1;
    start = 1'b1;
    @(posedge clk);
    #1;
    chk("abort_busy", 32'(busy), 32'h0);
    chk("abort_done", 32'(done), 32'h0);
    chk("abort_result", 32'(result), 32'(last_res));
    abort = 1'b0;
    start = 1'b0;
    @(posedge clk);
    #1;
    chk("abort_idle_busy", 32'(busy), 32'h0);
    chk("abort_idle_done", 32'(done), 32'h0);
    launch(2'b00, 9, 16'h0, 16'h0);
    wait_done("post_abort", lat, bcnt);
    chk("post_abort_res", 32'(result), 32'd34);
    chk("post_abort_lat", 32'(lat), 32'd10);

    // Abort while in DONE is ignored.
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    chk("abort_in_done_done", 32'(done), 32'h1);
    chk("abort_in_done_res", 32'(result), 32'd34);

    // Start pulsed high during CALC must not disturb the calculation.
    launch(2'b00, 12, 16'h0, 16'h0);
    lat = 0;
    for (int k = 1; k <= 40; k++) begin
      start = (k >= 2 && k <= 8);
      @(posedge clk);
      #1;
      if (done) begin
        lat = k;
        break;
      end
    end
    start = 1'b0;
    chk("start_in_calc_lat", 32'(lat), 32'd13);
    chk("start_in_calc_res", 32'(result), 32'd144);

    // Start held high with n=2: done for one cycle every 4 edges.
    @(negedge clk);
    mode  = 2'b00;
    n_in  = 5'd2;
    start = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk);
      #1;
      chk($sformatf("held_done_%0d", k), 32'(done), 32'((k % 4) == 3));
      if ((k % 4) == 3) chk($sformatf("held_res_%0d", k), 32'(result), 32'd1);
    end
    start = 1'b0;
    wait_done("held_drain", lat, bcnt);
    chk("held_drain_lat", 32'(lat), 32'd3);
    chk("held_drain_res", 32'(result), 32'd1);

    // Asynchronous reset between edges in the middle of CALC.
    launch(2'b00, 12, 16'h0, 16'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("async_rst_busy", 32'(busy), 32'h0);
    chk("async_rst_done", 32'(done), 32'h0);
    chk("async_rst_result", 32'(result), 32'h0);
    chk("async_rst_ovf", 32'(overflow), 32'h0);
    @(negedge clk);
    reset = 1'b0;
    launch(2'b00, 5, 16'h0, 16'h0);
    wait_done("post_rst", lat, bcnt);
    chk("post_rst_res", 32'(result), 32'd5);
    chk("post_rst_lat", 32'(lat), 32'd6);
    chk("post_rst_ovf", 32'(overflow), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
